// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for a single-port synchronous RAM with bounded-burst fairness.
// Optional ARB_ROUND_ROBIN_EN: round-robin IDLE tie-break and MAX_BURST preemption of both owners.
module ram_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ReqA,
  input  logic              ReqB,
  input  logic              WeA,
  input  logic              WeB,
  input  logic [ADDR_W-1:0] AddrA,
  input  logic [ADDR_W-1:0] AddrB,
  input  logic [DATA_W-1:0] WrDataA,
  input  logic [DATA_W-1:0] WrDataB,
  output logic              GntA,
  output logic              GntB,
  output logic              RdValidA,
  output logic              RdValidB,
  output logic [DATA_W-1:0] RdData,
  output logic              RamEn,
  output logic              RamWe,
  output logic [ADDR_W-1:0] RamAddr,
  output logic [DATA_W-1:0] RamWrData,
  input  logic [DATA_W-1:0] RamRdData
);

  localparam int BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [BW-1:0]   beats_r, beats_s, beats_inc_s;
  logic            gnt_a_s, gnt_b_s;
  logic            burst_done_s;
  logic            a_preempt_s, b_preempt_s;
  state_t          tie_s;
  logic            rd_valid_a_r, rd_valid_b_r;

`ifdef ARB_ROUND_ROBIN_EN
  logic            last_r;  // 1'b0 = A was last owner, 1'b1 = B

  assign a_preempt_s = 1'b1;
  assign b_preempt_s = 1'b1;
  assign tie_s       = (last_r == 1'b0) ? OWN_B : OWN_A;

  // previous-owner tracking, updated on each transferred beat
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      last_r <= 1'b1;
    end else if (gnt_a_s) begin
      last_r <= 1'b0;
    end else if (gnt_b_s) begin
      last_r <= 1'b1;
    end else begin
      last_r <= last_r;
    end
  end
`else
  assign a_preempt_s = 1'b0;
  assign b_preempt_s = 1'b1;
  assign tie_s       = OWN_A;
`endif

  assign gnt_a_s      = (state_r == OWN_A) && ReqA;
  assign gnt_b_s      = (state_r == OWN_B) && ReqB;
  // the beat being granted now counts toward the burst limit
  assign burst_done_s = ((32'(beats_r) + 32'd1) >= 32'(MAX_BURST));
  assign beats_inc_s  = (beats_r == BW'(MAX_BURST)) ? beats_r : beats_r + BW'(1);

  // next-state and burst counter logic
  always_comb begin
    state_s = state_r;
    beats_s = beats_r;
    case (state_r)
      IDLE: begin
        beats_s = '0;
        if (ReqA && ReqB) begin
          state_s = tie_s;
        end else if (ReqA) begin
          state_s = OWN_A;
        end else if (ReqB) begin
          state_s = OWN_B;
        end else begin
          state_s = IDLE;
        end
      end
      OWN_A: begin
        if (!ReqA) begin
          beats_s = '0;
          state_s = ReqB ? OWN_B : IDLE;
        end else if (ReqB && burst_done_s && a_preempt_s) begin
          beats_s = '0;
          state_s = OWN_B;
        end else begin
          beats_s = beats_inc_s;
          state_s = OWN_A;
        end
      end
      OWN_B: begin
        if (!ReqB) begin
          beats_s = '0;
          state_s = ReqA ? OWN_A : IDLE;
        end else if (ReqA && burst_done_s && b_preempt_s) begin
          beats_s = '0;
          state_s = OWN_A;
        end else begin
          beats_s = beats_inc_s;
          state_s = OWN_B;
        end
      end
      default: begin
        beats_s = '0;
        state_s = IDLE;
      end
    endcase
  end

  // state, burst counter and read-valid pipeline registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r      <= IDLE;
      beats_r      <= '0;
      rd_valid_a_r <= 1'b0;
      rd_valid_b_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      beats_r      <= beats_s;
      rd_valid_a_r <= gnt_a_s && !WeA;
      rd_valid_b_r <= gnt_b_s && !WeB;
    end
  end

  // RAM port mux driven from the current owner
  always_comb begin
    RamEn = gnt_a_s || gnt_b_s;
    RamWe = (gnt_a_s && WeA) || (gnt_b_s && WeB);
    if (state_r == OWN_B) begin
      RamAddr   = AddrB;
      RamWrData = WrDataB;
    end else begin
      RamAddr   = AddrA;
      RamWrData = WrDataA;
    end
  end

  assign GntA     = gnt_a_s;
  assign GntB     = gnt_b_s;
  assign RdValidA = rd_valid_a_r;
  assign RdValidB = rd_valid_b_r;
  // RAM output is already registered, so data is only gated by the valids
  assign RdData   = (rd_valid_a_r || rd_valid_b_r) ? RamRdData : '0;

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter sharing the single-port synchronous block RAM between the CPU controller (port A) and a peripheral/DMA master (port B, e.g. display scan-out). It sits between the CPU datapath's RAM address/data mux and the RAM macro, and sequences one access per clock with a bounded-burst fairness rule. All RAM traffic passes through it.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MAX_BURST, 4, max consecutive beats one owner keeps while the other is requesting (≥1)
- Clk  in  1  system clock, rising edge active
- Rst_n  in  1  asynchronous, active-low reset
- ReqA / ReqB  in  1  request; held with We/Addr/WrData stable until the beat is granted
- WeA / WeB  in  1  1 = write beat, 0 = read beat
- AddrA / AddrB  in  ADDR_W  beat address
- WrDataA / WrDataB  in  DATA_W  write data
- GntA / GntB  out  1  beat accepted at the next rising edge
- RdValidA / RdValidB  out  1  read data valid this cycle
- RdData  out  DATA_W  read data (shared; qualify with RdValidA/B)
- RamEn, RamWe  out  1  RAM enable / write enable
- RamAddr  out  ADDR_W, RamWrData  out  DATA_W  RAM address / write data
- RamRdData  in  DATA_W  RAM registered read output (1-cycle latency)

## Operation
- States: IDLE, OWN_A, OWN_B; burst counter `beats` (0..MAX_BURST, saturating); `last` bit records previous owner.
- Gnt_X = (state == OWN_X) && Req_X, combinational. GntA and GntB never both 1. In IDLE both 0.
- RAM port muxed from current owner: RamEn = GntA|GntB; RamWe = granted We; RamAddr/RamWrData from owner. RamEn=0 → RamWe=0, addr/data don't-care.
- A beat transfers at a rising edge where Gnt_X=1; beats increments (saturating).
- IDLE: neither Req → stay. One Req → that owner. Both → tie rule (Configuration). beats←0.
- OWN_X, Req_X=0: go OWN_Y if Req_Y, else IDLE; beats←0.
- OWN_X, Req_X=1, Req_Y=0: stay; beats saturates at MAX_BURST.
- OWN_X, Req_X=1, Req_Y=1: if beats+1 ≥ MAX_BURST (counting current beat) and X is preemptible → OWN_Y, beats←0; else stay.
- Ownership hand-over is bubble-free: OWN_A→OWN_B with no idle cycle.
- Read beat granted at edge N: RdValid_X=1 and RdData=RamRdData during cycle N+1 (one cycle). Write beats never raise RdValid.

## Timing
- Reset (async assert): state=IDLE, beats=0, last=B, GntA=GntB=0, RdValidA=RdValidB=0, RamEn=RamWe=0, RdData=0. Reset mid-read suppresses that read's RdValid.
- Arbitration latency from IDLE: Req at edge N sampled → Gnt high in cycle N+1.
- Owner with continuous Req: one beat per cycle, 100% throughput.
- Read latency: grant edge to RdValid = 1 cycle; back-to-back reads give RdValid every cycle.
- Dropping Req while granted releases ownership at the next edge; no beat occurs that cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined: IDLE tie goes to the requester not equal to `last`; both A and B preemptible by MAX_BURST.
- Not defined: IDLE tie always goes to A; A is never preempted (B waits until ReqA drops); B is preempted by MAX_BURST as above. `last` unused.

## Test plan
- Reset: Rst_n low mid-burst with RdValidA due → all outputs 0 immediately, no RdValid after release; first ReqA → GntA one cycle later.
- Single A reads of addresses 0x0010..0x0013 (RAM preloaded 0xA000+addr) → GntA 4 cycles, RdValidA next 4 cycles with RdData 0xA010..0xA013.
- A write 0x1234 to 0x0040 then A read 0x0040 back-to-back → RamWe 1 then 0, RdValidA once with 0x1234, RdValidB never.
- Both continuously requesting, MAX_BURST=4, RR enabled → grants A,A,A,A,B,B,B,B,A… with no idle cycle at hand-overs.
- Same stimulus, macro undefined → GntA every cycle, GntB never; drop ReqA → GntB next cycle.
- Simultaneous first requests from IDLE with last=A (RR) → B granted first; verify GntA&GntB never both 1 throughout.
